// File: rtl/rr_mux_arbiter_if.sv
// Bundle of the two input streams, the registered output stream, the mux select and the lock flag.
// The master modport is the arbiter side; the slave modport is the surrounding environment.
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i0_data;
    logic             i0_valid;
    logic             i0_last;
    logic             i0_ready;
    logic [WIDTH-1:0] i1_data;
    logic             i1_valid;
    logic             i1_last;
    logic             i1_ready;
    logic             S;
    logic [WIDTH-1:0] y_data;
    logic             y_valid;
    logic             y_last;
    logic             y_ready;
    logic             locked;

    modport master (
        input  i0_data, i0_valid, i0_last,
        output i0_ready,
        input  i1_data, i1_valid, i1_last,
        output i1_ready,
        output S, y_data, y_valid, y_last, locked,
        input  y_ready
    );

    modport slave (
        output i0_data, i0_valid, i0_last,
        input  i0_ready,
        output i1_data, i1_valid, i1_last,
        input  i1_ready,
        input  S, y_data, y_valid, y_last, locked,
        output y_ready
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Packet-aware two-channel round-robin arbiter driving the 2:1 mux select and a single
// registered valid/ready output stage, with a word-count watchdog on locked packets.
module rr_mux_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MAX_PKT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.master bus
);
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_PKT - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_r, state_n;
    logic             s_r, s_n;
    logic             arm_r, arm_n;
    logic             ptr_r, ptr_n;
    logic [CW-1:0]    cnt_r, cnt_n;
    logic [WIDTH-1:0] y_data_r, y_data_n;
    logic             y_valid_r, y_valid_n;
    logic             y_last_r, y_last_n;

    logic             free_s;
    logic             grant_ok_s;
    logic             rdy0_s;
    logic             rdy1_s;
    logic             xfer_s;
    logic             xlast_s;
    logic [WIDTH-1:0] xdata_s;

    // Handshake decode: arm_r says the registered select was chosen for a live request.
    always_comb begin
        free_s     = ~y_valid_r | bus.y_ready;
        grant_ok_s = (state_r == LOCKED) | arm_r;
        rdy0_s     = free_s & ~s_r & grant_ok_s;
        rdy1_s     = free_s &  s_r & grant_ok_s;
        xfer_s     = (rdy0_s & bus.i0_valid) | (rdy1_s & bus.i1_valid);
        xlast_s    = s_r ? bus.i1_last : bus.i0_last;
        xdata_s    = s_r ? bus.i1_data : bus.i0_data;
    end

    // Packet FSM next state, pointer and watchdog counter.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    if (xlast_s) begin
                        ptr_n = ~s_r;
                    end else begin
                        state_n = LOCKED;
                        cnt_n   = {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s) begin
                    if (xlast_s || (cnt_r >= CNT_LIM)) begin
                        state_n = IDLE;
                        ptr_n   = ~s_r;
                        cnt_n   = {CW{1'b0}};
                    end else begin
                        cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_n = LOCKED;
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = 1'b0;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    // Select arbitration for the next cycle; frozen while locked or stalled.
    always_comb begin
        s_n   = s_r;
        arm_n = arm_r;
        if (!free_s) begin
            s_n   = s_r;
            arm_n = arm_r;
        end else if (state_n == IDLE) begin
            if (bus.i0_valid && bus.i1_valid) begin
                s_n = ptr_n;
            end else if (bus.i0_valid) begin
                s_n = 1'b0;
            end else if (bus.i1_valid) begin
                s_n = 1'b1;
            end else begin
                s_n = s_r;
            end
            arm_n = s_n ? bus.i1_valid : bus.i0_valid;
        end else begin
            s_n   = s_r;
            arm_n = 1'b0;
        end
    end

    // Output stage next value: load on transfer, drain when free, hold when stalled.
    always_comb begin
        y_data_n  = y_data_r;
        y_last_n  = y_last_r;
        y_valid_n = y_valid_r;
        if (free_s) begin
            y_valid_n = xfer_s;
            if (xfer_s) begin
                y_data_n = xdata_s;
                y_last_n = xlast_s;
            end else begin
                y_data_n = y_data_r;
                y_last_n = y_last_r;
            end
        end else begin
            y_valid_n = y_valid_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            s_r       <= 1'b0;
            arm_r     <= 1'b0;
            ptr_r     <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            y_data_r  <= {WIDTH{1'b0}};
            y_valid_r <= 1'b0;
            y_last_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            s_r       <= s_n;
            arm_r     <= arm_n;
            ptr_r     <= ptr_n;
            cnt_r     <= cnt_n;
            y_data_r  <= y_data_n;
            y_valid_r <= y_valid_n;
            y_last_r  <= y_last_n;
        end
    end

    assign bus.i0_ready = rdy0_s;
    assign bus.i1_ready = rdy1_s;
    assign bus.S        = s_r;
    assign bus.y_data   = y_data_r;
    assign bus.y_valid  = y_valid_r;
    assign bus.y_last   = y_last_r;
    assign bus.locked   = (state_r == LOCKED);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, alternation, packet lock, back-pressure,
// watchdog release and mid-packet reset, each against hand-computed output words.
module tb_rr_mux_arbiter;
    localparam int WIDTH   = 8;
    localparam int MAX_PKT = 16;

    logic clk = 1'b0;
    logic rst_n;

    rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_PKT(MAX_PKT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Source queues hold {last, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.i0_valid = (q0.size() > 0);
        bus.i0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        bus.i0_last  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
        bus.i1_valid = (q1.size() > 0);
        bus.i1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        bus.i1_last  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
    endtask

    // One clock: present heads, note handshakes, pop accepted words, settle past the edge.
    task automatic step();
        logic a0, a1;
        drive();
        #2;
        a0 = bus.i0_valid & bus.i0_ready;
        a1 = bus.i1_valid & bus.i1_ready;
        @(posedge clk);
        if (a0 === 1'b1) void'(q0.pop_front());
        if (a1 === 1'b1) void'(q1.pop_front());
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_alt [8];
        logic       exp_s   [8];
        logic [7:0] exp_wd  [19];
        logic       exp_lk  [19];

        exp_alt = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        exp_s   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 16; k++) begin
            exp_wd[k] = 8'h40 + 8'(k);
            exp_lk[k] = (k < 15);
        end
        exp_wd[16] = 8'h60; exp_lk[16] = 1'b0;
        exp_wd[17] = 8'h50; exp_lk[17] = 1'b1;
        exp_wd[18] = 8'h51; exp_lk[18] = 1'b1;

        rst_n       = 1'b0;
        bus.y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q0.push_back({1'b1, 8'h10 + 8'(k)});
            q1.push_back({1'b1, 8'h20 + 8'(k)});
        end
        @(posedge clk);
        #1;

        // Reset held with both channels valid.
        for (int k = 0; k < 3; k++) step();
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_i0_ready", 32'(bus.i0_ready), 32'd0);
        chk("rst_i1_ready", 32'(bus.i1_ready), 32'd0);
        chk("rst_y_data", 32'(bus.y_data), 32'd0);

        // First cycle after release only registers the decision.
        rst_n = 1'b1;
        step();
        chk("rel_y_valid", 32'(bus.y_valid), 32'd0);
        chk("rel_i0_ready", 32'(bus.i0_ready), 32'd1);

        // Alternating single-word packets, one word per cycle.
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("alt_valid%0d", k), 32'(bus.y_valid), 32'd1);
            chk($sformatf("alt_data%0d", k), 32'(bus.y_data), 32'(exp_alt[k]));
            chk($sformatf("alt_S%0d", k), 32'(bus.S), 32'(exp_s[k]));
        end
        step();
        chk("alt_drain", 32'(bus.y_valid), 32'd0);

        // Packet lock: ch0 4-word packet while ch1 waits.
        for (int k = 0; k < 4; k++) q0.push_back({(k == 3), 8'hA0 + 8'(k)});
        q1.push_back({1'b1, 8'h30});
        step();
        chk("lk_arb_valid", 32'(bus.y_valid), 32'd0);
        chk("lk_arb_locked", 32'(bus.locked), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("lk_data%0d", k), 32'(bus.y_data), 32'(8'hA0 + 8'(k)));
            chk($sformatf("lk_locked%0d", k), 32'(bus.locked), 32'((k < 3) ? 1 : 0));
        end
        chk("lk_last", 32'(bus.y_last), 32'd1);
        step();
        chk("lk_ch1_data", 32'(bus.y_data), 32'h30);
        chk("lk_ch1_valid", 32'(bus.y_valid), 32'd1);

        // Back-pressure mid-packet.
        for (int k = 0; k < 4; k++) q0.push_back({(k == 3), 8'hB0 + 8'(k)});
        step();
        chk("bp_idle_valid", 32'(bus.y_valid), 32'd0);
        step();
        chk("bp_b0", 32'(bus.y_data), 32'hB0);
        step();
        chk("bp_b1", 32'(bus.y_data), 32'hB1);
        bus.y_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp_hold_data%0d", k), 32'(bus.y_data), 32'hB1);
            chk($sformatf("bp_hold_valid%0d", k), 32'(bus.y_valid), 32'd1);
            chk($sformatf("bp_rdy0_%0d", k), 32'(bus.i0_ready), 32'd0);
            chk($sformatf("bp_rdy1_%0d", k), 32'(bus.i1_ready), 32'd0);
            chk($sformatf("bp_locked%0d", k), 32'(bus.locked), 32'd1);
        end
        bus.y_ready = 1'b1;
        step();
        chk("bp_b2", 32'(bus.y_data), 32'hB2);
        step();
        chk("bp_b3", 32'(bus.y_data), 32'hB3);
        chk("bp_unlocked", 32'(bus.locked), 32'd0);

        // Watchdog: 20 ch1 words with no last, ch0 waiting with one word.
        step();
        chk("wd_idle_valid", 32'(bus.y_valid), 32'd0);
        for (int k = 0; k < 20; k++) q1.push_back({1'b0, 8'h40 + 8'(k)});
        q0.push_back({1'b1, 8'h60});
        step();
        chk("wd_arb_S", 32'(bus.S), 32'd1);
        for (int k = 0; k < 19; k++) begin
            step();
            chk($sformatf("wd_data%0d", k), 32'(bus.y_data), 32'(exp_wd[k]));
            chk($sformatf("wd_locked%0d", k), 32'(bus.locked), 32'(exp_lk[k]));
        end

        // Reset during word 2 of the re-arbitrated ch1 packet.
        rst_n = 1'b0;
        step();
        chk("mrst_locked", 32'(bus.locked), 32'd0);
        chk("mrst_S", 32'(bus.S), 32'd0);
        chk("mrst_y_valid", 32'(bus.y_valid), 32'd0);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Two-channel, packet-aware round-robin arbiter that owns the select line of the team's 2:1 mux datapath.
- It accepts two valid/ready input streams and chooses one per packet.
- It drives the mux select S and registers the chosen word into a single output stage with a valid/ready interface.
- It sits directly upstream of the 2:1 mux and generates its S input.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- MAX_PKT, 16, maximum words per locked packet before the grant is forcibly released (watchdog).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- i0_data  input  WIDTH  channel 0 word (mux I0).
- i0_valid  input  1  channel 0 word valid.
- i0_last  input  1  channel 0 word ends packet.
- i0_ready  output  1  channel 0 word accepted this cycle.
- i1_data  input  WIDTH  channel 1 word (mux I1).
- i1_valid  input  1  channel 1 word valid.
- i1_last  input  1  channel 1 word ends packet.
- i1_ready  output  1  channel 1 word accepted this cycle.
- S  output  1  mux select, registered: 0 = I0, 1 = I1.
- y_data  output  WIDTH  registered output word.
- y_valid  output  1  y_data holds a word.
- y_last  output  1  y_data ends packet.
- y_ready  input  1  downstream accepts y_data.
- locked  output  1  a packet is in progress.

Behaviour:
- Reset, when rst_n = 0 at a clock edge, clears the following:
  - S = 0, y_valid = 0, y_data = 0, y_last = 0, locked = 0.
  - Round-robin pointer favours channel 0 first.
  - Word counter = 0.
- Output register is free when y_valid = 0 or y_ready = 1.
- At most one input is ready per cycle: i<k>_ready = free & (S == k) & state allows grant.
- Transfer on channel k happens when i<k>_valid & i<k>_ready.
  - y_data/y_last load from channel k at the next edge; y_valid = 1.
  - Input-to-output latency is 1 cycle.
- When free and no transfer occurs, y_valid = 0 at the next edge.
- When not free, y_data, y_valid and y_last hold.
- State machine has two states, IDLE and LOCKED:
  - IDLE: S already points at the channel to serve.
  - In IDLE, S is updated every cycle from the pointer and the requests:
    - both valid → pointer channel;
    - one valid → that channel;
    - none valid → S holds.
  - The arbitration decision is registered, so a request seen in cycle n is accepted no earlier than cycle n+1.
  - IDLE → LOCKED on a transfer with last = 0; the counter loads 1.
  - IDLE, transfer with last = 1 (single-word packet): stay IDLE; pointer = ~S.
  - LOCKED: S is frozen and only the granted channel may transfer. The counter increments per transfer.
  - LOCKED → IDLE on a transfer with last = 1, or when the counter reaches MAX_PKT. On exit, pointer = ~S and the counter clears.
  - Watchdog release does not alter the data stream. The remaining words of that packet re-arbitrate as a new packet.
- locked = 1 exactly while in LOCKED.
- No words are dropped or duplicated. Order within a channel is preserved.
- Back-pressure: if y_ready = 0 and y_valid = 1, both input readies are 0 and all state holds.
- Valid is low between packets: S holds, so there is no spurious select toggle.
- Reset mid-packet returns to IDLE immediately. The partial packet is abandoned, with no recovery.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with both valid high → S = 0, y_valid = 0, locked = 0, both readies 0; first accept is ch0 one cycle after release.
- Alternation: both channels send single-word packets continuously (ch0 = 0x10.., ch1 = 0x20..), y_ready = 1 → output 0x10, 0x20, 0x11, 0x21…, S toggles every word, one word per cycle after 1-cycle latency.
- Packet lock: ch0 sends 4-word packet A0..A3 (last on A3) while ch1 is valid → y = A0, A1, A2, A3 then ch1's word; locked = 1 from the edge after A0 until the edge after A3.
- Back-pressure: drop y_ready for 5 cycles mid-packet → y_data/y_valid stable, i0_ready = i1_ready = 0; resumes with the next word, no loss or duplicate.
- Watchdog: MAX_PKT = 16, ch1 sends 20 words with no last and ch0 is waiting → after 16 ch1 words, ch0 is served next and locked drops for one arbitration.
- Reset mid-packet: assert rst_n = 0 during word 2 of a ch1 packet → next cycle locked = 0, S = 0, y_valid = 0.
